hazard_ctrl_mdu: RTL and testbench

//  Parametrised hazard controller for the 5-stage pipelined MIPS core (F/D/E/M/W).

---
 rtl/hazard_pkg.sv | 11 +
 rtl/hazard_ctrl_mdu_tracker.sv | 30 +++
 rtl/hazard_ctrl_mdu.sv | 122 ++++++++++++
 tb/tb_hazard_ctrl_mdu.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard controller: forwarding-select encodings
// and the default register-address width.
package hazard_pkg;

  localparam int REG_AW_DEF = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

endpackage

// File: rtl/hazard_ctrl_mdu_tracker.sv
// MDU busy tracker: a down-counter loaded with MDU_LAT when an MDU op leaves E.
// A new start while busy reloads the counter, so the newest op sets the timing.
module mdu_busy_tracker #(
  parameter int MDU_LAT = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic mdu_start,
  output logic mdu_busy
);

  localparam int CNT_W = $clog2(MDU_LAT + 1);

  logic [CNT_W-1:0] r_cnt;

  // Busy counter: reload on start, otherwise count down to zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (mdu_start) begin
      r_cnt <= CNT_W'(MDU_LAT);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // Gated by rst_n so the output is 0 during reset even before the first edge.
  assign mdu_busy = rst_n && (r_cnt != '0);

endmodule

// File: rtl/hazard_ctrl_mdu.sv
// Hazard controller for the 5-stage MIPS pipeline: E/D forwarding selects,
// load-use / branch / MDU stalls, E flush, and an MDU busy tracker.
// Optional feature macro: HAZ_PERF_CNT_EN adds a saturating stall-cycle counter
// on the stall_cnt port; without it the port and register are absent.
module hazard_ctrl_mdu
  import hazard_pkg::*;
#(
  parameter int REG_AW  = REG_AW_DEF,
  parameter int MDU_LAT = 32,
  parameter int PERF_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rs_d,
  input  logic [REG_AW-1:0] rt_d,
  input  logic              branch_d,
  input  logic              mdu_use_d,
  input  logic [REG_AW-1:0] rs_e,
  input  logic [REG_AW-1:0] rt_e,
  input  logic [REG_AW-1:0] write_reg_e,
  input  logic              reg_write_e,
  input  logic              mem_to_reg_e,
  input  logic              mdu_start_e,
  input  logic [REG_AW-1:0] write_reg_m,
  input  logic              reg_write_m,
  input  logic              mem_to_reg_m,
  input  logic [REG_AW-1:0] write_reg_w,
  input  logic              reg_write_w,
  output logic [1:0]        fwd_a_e,
  output logic [1:0]        fwd_b_e,
  output logic              fwd_a_d,
  output logic              fwd_b_d,
  output logic              stall_f,
  output logic              stall_d,
  output logic              flush_e,
  output logic              mdu_busy
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] stall_cnt
`endif
);

  // Parameter sanity: an MDU op must occupy at least one cycle and the
  // counter width must be usable.
  if (MDU_LAT < 1 || PERF_W < 1) begin : g_param_check
    $error("hazard_ctrl_mdu: MDU_LAT and PERF_W must be >= 1");
  end

  // Register 0 is hard-wired zero, so it never matches a producer.
  function automatic logic reg_match(input logic [REG_AW-1:0] a,
                                     input logic [REG_AW-1:0] b);
    return (a == b) && (a != '0);
  endfunction

  logic w_mdu_busy;
  logic w_lw_stall;
  logic w_br_stall;
  logic w_mdu_stall;
  logic w_stall;

  mdu_busy_tracker #(
    .MDU_LAT (MDU_LAT)
  ) u_mdu_busy_tracker (
    .clk       (clk),
    .rst_n     (rst_n),
    .mdu_start (mdu_start_e),
    .mdu_busy  (w_mdu_busy)
  );

  // Forwarding selects and stall detection; everything forced low in reset.
  always_comb begin
    fwd_a_e     = FWD_RF;
    fwd_b_e     = FWD_RF;
    fwd_a_d     = 1'b0;
    fwd_b_d     = 1'b0;
    w_lw_stall  = 1'b0;
    w_br_stall  = 1'b0;
    w_mdu_stall = 1'b0;
    if (rst_n) begin
      // M has priority over W because it holds the younger result.
      if (reg_write_m && reg_match(rs_e, write_reg_m))      fwd_a_e = FWD_MEM;
      else if (reg_write_w && reg_match(rs_e, write_reg_w)) fwd_a_e = FWD_WB;
      if (reg_write_m && reg_match(rt_e, write_reg_m))      fwd_b_e = FWD_MEM;
      else if (reg_write_w && reg_match(rt_e, write_reg_w)) fwd_b_e = FWD_WB;

      // Only ALUOut can reach the comparator from M; loads are not ready yet.
      fwd_a_d = reg_match(rs_d, write_reg_m) && reg_write_m && !mem_to_reg_m;
      fwd_b_d = reg_match(rt_d, write_reg_m) && reg_write_m && !mem_to_reg_m;

      w_lw_stall  = mem_to_reg_e &&
                    (reg_match(rs_d, write_reg_e) || reg_match(rt_d, write_reg_e));
      w_br_stall  = branch_d &&
                    ((reg_write_e &&
                      (reg_match(rs_d, write_reg_e) || reg_match(rt_d, write_reg_e))) ||
                     (mem_to_reg_m &&
                      (reg_match(rs_d, write_reg_m) || reg_match(rt_d, write_reg_m))));
      w_mdu_stall = mdu_use_d && (w_mdu_busy || mdu_start_e);
    end
  end

  assign w_stall  = w_lw_stall | w_br_stall | w_mdu_stall;
  assign stall_f  = w_stall;
  assign stall_d  = w_stall;
  assign flush_e  = w_stall;
  assign mdu_busy = w_mdu_busy;

`ifdef HAZ_PERF_CNT_EN
  logic [PERF_W-1:0] r_stall_cnt;

  // Saturating count of stall cycles since reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + PERF_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_hazard_ctrl_mdu.sv
// Directed bench for hazard_ctrl_mdu with MDU_LAT=4 (and PERF_W=3 so the
// optional stall counter saturates quickly when HAZ_PERF_CNT_EN is defined).
module tb_hazard_ctrl_mdu;

  logic       clk;
  logic       rst_n;
  logic [4:0] rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w;
  logic       branch_d, mdu_use_d, reg_write_e, mem_to_reg_e, mdu_start_e;
  logic       reg_write_m, mem_to_reg_m, reg_write_w;
  logic [1:0] fwd_a_e, fwd_b_e;
  logic       fwd_a_d, fwd_b_d, stall_f, stall_d, flush_e, mdu_busy;
`ifdef HAZ_PERF_CNT_EN
  logic [2:0] stall_cnt;
`endif

  int checks = 0;
  int failures = 0;
  logic [2:0] perf_model = '0;

  string      q_tag[$];
  logic [9:0] q_exp[$];

  hazard_ctrl_mdu #(
    .REG_AW  (5),
    .MDU_LAT (4),
    .PERF_W  (3)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rs_d         (rs_d),
    .rt_d         (rt_d),
    .branch_d     (branch_d),
    .mdu_use_d    (mdu_use_d),
    .rs_e         (rs_e),
    .rt_e         (rt_e),
    .write_reg_e  (write_reg_e),
    .reg_write_e  (reg_write_e),
    .mem_to_reg_e (mem_to_reg_e),
    .mdu_start_e  (mdu_start_e),
    .write_reg_m  (write_reg_m),
    .reg_write_m  (reg_write_m),
    .mem_to_reg_m (mem_to_reg_m),
    .write_reg_w  (write_reg_w),
    .reg_write_w  (reg_write_w),
    .fwd_a_e      (fwd_a_e),
    .fwd_b_e      (fwd_b_e),
    .fwd_a_d      (fwd_a_d),
    .fwd_b_d      (fwd_b_d),
    .stall_f      (stall_f),
    .stall_d      (stall_d),
    .flush_e      (flush_e),
    .mdu_busy     (mdu_busy)
`ifdef HAZ_PERF_CNT_EN
    ,
    .stall_cnt    (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {fwd_a_e, fwd_b_e, fwd_a_d, fwd_b_d, stall_f, stall_d, flush_e, mdu_busy}
  function automatic logic [9:0] ev(input logic [1:0] fa, input logic [1:0] fb,
                                    input logic ad, input logic bd,
                                    input logic st, input logic bz);
    return {fa, fb, ad, bd, st, st, st, bz};
  endfunction

  task automatic clear_inputs();
    rs_d = '0; rt_d = '0; rs_e = '0; rt_e = '0;
    write_reg_e = '0; write_reg_m = '0; write_reg_w = '0;
    branch_d = 1'b0; mdu_use_d = 1'b0; reg_write_e = 1'b0; mem_to_reg_e = 1'b0;
    mdu_start_e = 1'b0; reg_write_m = 1'b0; mem_to_reg_m = 1'b0; reg_write_w = 1'b0;
  endtask

  // Push the expectation for the current inputs, compare at the falling edge,
  // then advance one cycle.
  task automatic step(input string tag, input logic [9:0] e);
    string      t;
    logic [9:0] x;
    logic [9:0] obs;
    q_tag.push_back(tag);
    q_exp.push_back(e);
    @(negedge clk);
    t   = q_tag.pop_front();
    x   = q_exp.pop_front();
    obs = {fwd_a_e, fwd_b_e, fwd_a_d, fwd_b_d, stall_f, stall_d, flush_e, mdu_busy};
    checks++;
    assert (obs === x) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", t, obs, x);
    end
`ifdef HAZ_PERF_CNT_EN
    checks++;
    assert (stall_cnt === perf_model) else begin
      failures++;
      $error("FAIL %s_stall_cnt observed=%0d expected=%0d", t, stall_cnt, perf_model);
    end
`endif
    if (!rst_n) perf_model = '0;
    else if (x[3] && perf_model != 3'b111) perf_model = perf_model + 3'd1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    @(posedge clk);
    #1;

    // Reset: inputs that would forward/stall are ignored.
    rs_e = 5'd3; write_reg_m = 5'd3; reg_write_m = 1'b1;
    mdu_use_d = 1'b1; mdu_start_e = 1'b1;
    step("reset_outputs", ev(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
    clear_inputs();
    rst_n = 1'b1;

    // 1: M wins over W; $0 never forwards.
    rs_e = 5'd3; write_reg_m = 5'd3; reg_write_m = 1'b1; write_reg_w = 5'd3; reg_write_w = 1'b1;
    step("fwd_m_wins", ev(2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
    rs_e = 5'd0; write_reg_m = 5'd0; write_reg_w = 5'd0;
    step("fwd_reg0", ev(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
    clear_inputs();
    rt_e = 5'd7; write_reg_w = 5'd7; reg_write_w = 1'b1; write_reg_m = 5'd8; reg_write_m = 1'b1;
    step("fwd_b_from_w", ev(2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0));

    // 2: load-use stall, then forward from W.
    clear_inputs();
    mem_to_reg_e = 1'b1; reg_write_e = 1'b1; write_reg_e = 5'd5; rt_d = 5'd5;
    step("lw_stall", ev(2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0));
    clear_inputs();
    mem_to_reg_m = 1'b1; reg_write_m = 1'b1; write_reg_m = 5'd5; rt_d = 5'd5;
    step("lw_in_m_no_stall", ev(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
    clear_inputs();
    rt_e = 5'd5; write_reg_w = 5'd5; reg_write_w = 1'b1;
    step("lw_fwd_w", ev(2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0));
    clear_inputs();
    mem_to_reg_e = 1'b1; reg_write_e = 1'b1; write_reg_e = 5'd0; rt_d = 5'd0;
    step("lw_reg0_no_stall", ev(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));

    // 3: branch hazards.
    clear_inputs();
    branch_d = 1'b1; rs_d = 5'd4; rt_d = 5'd6; reg_write_e = 1'b1; write_reg_e = 5'd4;
    step("br_stall_e", ev(2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0));
    clear_inputs();
    branch_d = 1'b1; rs_d = 5'd4; rt_d = 5'd6; reg_write_m = 1'b1; write_reg_m = 5'd4;
    step("br_fwd_a_d", ev(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0));
    mem_to_reg_m = 1'b1;
    step("br_load_m_stall", ev(2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0));
    mem_to_reg_m = 1'b0; write_reg_m = 5'd6;
    step("br_fwd_b_d", ev(2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0));

    // 4: MDU latency 4 with mflo waiting in D; counter cleared first.
    clear_inputs();
    rst_n = 1'b0;
    step("reset_pre_mdu", ev(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
    rst_n = 1'b1;
    mdu_start_e = 1'b1; mdu_use_d = 1'b1;
    step("mdu_c0", ev(2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0));
    mdu_start_e = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step($sformatf("mdu_c%0d", i), ev(2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1));
    end
    step("mdu_c5_release", ev(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
`ifdef HAZ_PERF_CNT_EN
    checks++;
    assert (stall_cnt === 3'd5) else begin
      failures++;
      $error("FAIL perf_after_mdu observed=%0d expected=5", stall_cnt);
    end
`endif

    // MDU reload while busy: newest op restarts the count.
    clear_inputs();
    mdu_start_e = 1'b1;
    step("reload_c0", ev(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
    mdu_start_e = 1'b0;
    step("reload_c1", ev(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1));
    mdu_start_e = 1'b1;
    step("reload_c2", ev(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1));
    mdu_start_e = 1'b0;
    for (int i = 3; i <= 6; i++) begin
      step($sformatf("reload_c%0d", i), ev(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1));
    end
    step("reload_c7_idle", ev(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));

    // Forced branch stall for 10 cycles: stall counter saturates at 7.
    clear_inputs();
    branch_d = 1'b1; rs_d = 5'd4; reg_write_e = 1'b1; write_reg_e = 5'd4;
    for (int i = 0; i < 10; i++) begin
      step($sformatf("sat_stall_%0d", i), ev(2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0));
    end
    clear_inputs();
    step("sat_hold", ev(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
`ifdef HAZ_PERF_CNT_EN
    checks++;
    assert (stall_cnt === 3'd7) else begin
      failures++;
      $error("FAIL perf_saturated observed=%0d expected=7", stall_cnt);
    end
`endif

    // 5: reset mid-MDU-op abandons it.
    clear_inputs();
    mdu_start_e = 1'b1;
    step("abort_c0", ev(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
    mdu_start_e = 1'b0;
    step("abort_c1", ev(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1));
    rst_n = 1'b0; mdu_use_d = 1'b1; mdu_start_e = 1'b1;
    step("abort_in_reset", ev(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
    rst_n = 1'b1; mdu_start_e = 1'b0;
    step("abort_released", ev(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
    step("abort_quiet", ev(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
